// File: rtl/cpu_execute_pkg.sv
// Shared types for the execute stage: ALU opcodes, cache modes, FSM states and
// the execute->commit register layout. Width macros default here when not
// supplied by the build.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef NUM_ALU_OPS
`define NUM_ALU_OPS 8
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

package cpu_execute_pkg;

  localparam int unsigned RegWidth   = `REG_WIDTH;
  localparam int unsigned AluOpWidth = $clog2(`NUM_ALU_OPS);
  localparam int unsigned RegIdWidth = $clog2(`NUM_REGS);
  localparam int unsigned ShamtWidth = $clog2(`REG_WIDTH);

  typedef logic [RegWidth-1:0]   word_t;
  typedef logic [RegIdWidth-1:0] reg_id_t;

  typedef enum logic [AluOpWidth-1:0] {
    AluAdd,
    AluSub,
    AluMul,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl
  } alu_op_e;

  typedef enum logic [1:0] {
    CacheWb,
    CacheWt,
    CacheUc,
    CacheBypass
  } cache_mode_e;

  typedef enum logic {
    StIdle,
    StMulBusy
  } exec_state_e;

  typedef struct packed {
    word_t       result;
    word_t       store_data;
    reg_id_t     reg_dest;
    logic        mem_write;
    logic        mem_read;
    cache_mode_e mode;
    logic        mem_to_reg;
    logic        reg_write;
  } ex_commit_t;

  // Second ALU operand: register B or the immediate offset.
  function automatic word_t pick_b(logic use_reg_b, word_t rb, word_t offset);
    return use_reg_b ? rb : offset;
  endfunction

  // Register 0 is hard-wired, so it never takes a forwarded value.
  function automatic logic fwd_hit(logic fwd_valid, reg_id_t fwd_id, reg_id_t op_id);
    return fwd_valid && (fwd_id == op_id) && (op_id != '0);
  endfunction

endpackage

// File: rtl/cpu_execute_stage_if.sv
// Decode->execute->commit bundle. slave = the execute stage, master = the
// surrounding pipeline. Forwarding signals exist only with CPU_EXEC_FORWARD_EN.
interface cpu_execute_stage_if;
  import cpu_execute_pkg::*;

  // Decode side
  logic        in_valid;
  logic        in_ready;
  alu_op_e     alu_op;
  logic        use_reg_b;
  word_t       ra_data;
  word_t       rb_data;
  word_t       offset_data;
  reg_id_t     reg_dest;
  logic        mem_write;
  logic        mem_read;
  cache_mode_e mode;
  logic        mem_to_reg;
  logic        reg_write;
`ifdef CPU_EXEC_FORWARD_EN
  reg_id_t     ra_id;
  reg_id_t     rb_id;
  logic        fwd_valid;
  reg_id_t     fwd_reg_id;
  word_t       fwd_data;
`endif

  // Commit side
  logic        out_valid;
  logic        out_ready;
  word_t       out_result;
  word_t       out_store_data;
  reg_id_t     out_reg_dest;
  logic        out_mem_write;
  logic        out_mem_read;
  cache_mode_e out_mode;
  logic        out_mem_to_reg;
  logic        out_reg_write;

  modport slave (
    input  in_valid, alu_op, use_reg_b, ra_data, rb_data, offset_data, reg_dest,
    input  mem_write, mem_read, mode, mem_to_reg, reg_write,
`ifdef CPU_EXEC_FORWARD_EN
    input  ra_id, rb_id, fwd_valid, fwd_reg_id, fwd_data,
`endif
    output in_ready,
    output out_valid, out_result, out_store_data, out_reg_dest, out_mem_write,
    output out_mem_read, out_mode, out_mem_to_reg, out_reg_write,
    input  out_ready
  );

  modport master (
    output in_valid, alu_op, use_reg_b, ra_data, rb_data, offset_data, reg_dest,
    output mem_write, mem_read, mode, mem_to_reg, reg_write,
`ifdef CPU_EXEC_FORWARD_EN
    output ra_id, rb_id, fwd_valid, fwd_reg_id, fwd_data,
`endif
    input  in_ready,
    input  out_valid, out_result, out_store_data, out_reg_dest, out_mem_write,
    input  out_mem_read, out_mode, out_mem_to_reg, out_reg_write,
    output out_ready
  );

endinterface

// File: rtl/cpu_alu.sv
// Combinational single-cycle ALU. MUL is handled by the iterative path in the
// execute stage, so it (and any unused encoding) yields 0 here.
module cpu_alu
  import cpu_execute_pkg::*;
(
  input  alu_op_e op_i,
  input  word_t   a_i,
  input  word_t   b_i,
  output word_t   result_o
);

  logic [ShamtWidth-1:0] shamt;
  assign shamt = b_i[ShamtWidth-1:0];

  // Decode the operation; arithmetic wraps at the register width.
  always_comb begin
    result_o = '0;
    case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluXor:  result_o = a_i ^ b_i;
      AluSll:  result_o = a_i << shamt;
      AluSrl:  result_o = a_i >> shamt;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_execute_stage.sv
// Execute stage: single-cycle ALU ops land in the commit register one cycle
// after accept; MUL iterates for MUL_CYCLES before writing. Optional operand
// forwarding is enabled with the CPU_EXEC_FORWARD_EN macro.
module cpu_execute_stage
  import cpu_execute_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  cpu_execute_stage_if.slave bus
);

  localparam int unsigned CntWidth = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(MUL_CYCLES - 1);

  exec_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  word_t               mul_a_q, mul_b_q;
  ex_commit_t          mul_ctl_q;
  ex_commit_t          out_q, out_d;
  logic                out_valid_q;

  word_t      ra_eff, rb_eff, op_b, alu_res, mul_res;
  alu_op_e    eff_op;
  ex_commit_t acc_ctl;
  logic       load_en, in_ready, accept, is_mul, out_wr, mul_start;

`ifdef CPU_EXEC_FORWARD_EN
  assign ra_eff = fwd_hit(bus.fwd_valid, bus.fwd_reg_id, bus.ra_id) ? bus.fwd_data : bus.ra_data;
  assign rb_eff = fwd_hit(bus.fwd_valid, bus.fwd_reg_id, bus.rb_id) ? bus.fwd_data : bus.rb_data;
`else
  assign ra_eff = bus.ra_data;
  assign rb_eff = bus.rb_data;
`endif

  // Loads and stores compute their address with ADD whatever opcode decode sent.
  assign eff_op  = (bus.mem_read || bus.mem_write) ? AluAdd : bus.alu_op;
  assign is_mul  = (eff_op == AluMul);
  assign op_b    = pick_b(bus.use_reg_b, rb_eff, bus.offset_data);
  assign mul_res = mul_a_q * mul_b_q;
  assign load_en = !out_valid_q || bus.out_ready;

  cpu_alu u_alu (
    .op_i     (eff_op),
    .a_i      (ra_eff),
    .b_i      (op_b),
    .result_o (alu_res)
  );

  // Assemble the commit record for the instruction presented by decode.
  always_comb begin
    acc_ctl            = '0;
    acc_ctl.result     = alu_res;
    acc_ctl.store_data = rb_eff;
    acc_ctl.reg_dest   = bus.reg_dest;
    acc_ctl.mem_write  = bus.mem_write;
    acc_ctl.mem_read   = bus.mem_read;
    acc_ctl.mode       = bus.mode;
    acc_ctl.mem_to_reg = bus.mem_to_reg;
    acc_ctl.reg_write  = bus.reg_write;
  end

  // FSM state register with the MUL countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; flush beats everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mul_start) begin
            state_d = StMulBusy;
            cnt_d   = CntLoad;
          end
        end
        StMulBusy: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntWidth'(1);
          end else if (load_en) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: handshake and commit-register write strobe/data.
  always_comb begin
    in_ready  = 1'b0;
    accept    = 1'b0;
    mul_start = 1'b0;
    out_wr    = 1'b0;
    out_d     = out_q;
    unique case (state_q)
      StIdle: begin
        in_ready  = rst_n && load_en && !flush;
        accept    = bus.in_valid && in_ready;
        mul_start = accept && is_mul;
        if (accept && !is_mul) begin
          out_wr = 1'b1;
          out_d  = acc_ctl;
        end
      end
      StMulBusy: begin
        if ((cnt_q == '0) && load_en && !flush) begin
          out_wr       = 1'b1;
          out_d        = mul_ctl_q;
          out_d.result = mul_res;
        end
      end
      default: ;
    endcase
  end

  // Capture MUL operands and control at accept; held while iterating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_ctl_q <= '0;
    end else if (mul_start) begin
      mul_a_q   <= ra_eff;
      mul_b_q   <= op_b;
      mul_ctl_q <= acc_ctl;
    end
  end

  // Execute->commit register: load on write, drop valid on drain or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_wr) begin
      out_q       <= out_d;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = out_q.result;
  assign bus.out_store_data = out_q.store_data;
  assign bus.out_reg_dest   = out_q.reg_dest;
  assign bus.out_mem_write  = out_q.mem_write;
  assign bus.out_mem_read   = out_q.mem_read;
  assign bus.out_mode       = out_q.mode;
  assign bus.out_mem_to_reg = out_q.mem_to_reg;
  assign bus.out_reg_write  = out_q.reg_write;

endmodule

// File: tb/tb_cpu_execute_stage.sv
// Directed bench for cpu_execute_stage (MUL_CYCLES = 4). Forwarding cases are
// included when CPU_EXEC_FORWARD_EN is defined.
module tb_cpu_execute_stage;
  import cpu_execute_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  cpu_execute_stage_if bus ();

  cpu_execute_stage #(
    .MUL_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_e op, input logic urb, input word_t a, input word_t b,
                       input word_t off);
    bus.in_valid    = 1'b1;
    bus.alu_op      = op;
    bus.use_reg_b   = urb;
    bus.ra_data     = a;
    bus.rb_data     = b;
    bus.offset_data = off;
  endtask

  initial begin
    rst_n           = 1'b0;
    flush           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.alu_op      = AluAdd;
    bus.use_reg_b   = 1'b0;
    bus.ra_data     = '0;
    bus.rb_data     = '0;
    bus.offset_data = '0;
    bus.reg_dest    = '0;
    bus.mem_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mode        = CacheWb;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.out_ready   = 1'b1;
`ifdef CPU_EXEC_FORWARD_EN
    bus.ra_id       = '0;
    bus.rb_id       = '0;
    bus.fwd_valid   = 1'b0;
    bus.fwd_reg_id  = '0;
    bus.fwd_data    = '0;
`endif

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_reg_write", 32'(bus.out_reg_write), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD 5 + 7 (immediate)
    drive(AluAdd, 1'b0, 32'd5, 32'd0, 32'd7);
    bus.reg_dest  = 5'd4;
    bus.reg_write = 1'b1;
    tick();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_result", bus.out_result, 32'd12);
    chk("add_reg_dest", 32'(bus.out_reg_dest), 32'd4);
    chk("add_reg_write", 32'(bus.out_reg_write), 32'd1);

    // Back-to-back: SUB 0 - 1 accepted while ADD drains
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    drive(AluSub, 1'b1, 32'd0, 32'd1, 32'd0);
    tick();
    chk("sub_result", bus.out_result, 32'hFFFF_FFFF);
    chk("sub_valid", 32'(bus.out_valid), 32'd1);

    drive(AluSll, 1'b0, 32'd1, 32'd0, 32'd33);
    tick();
    chk("sll_result", bus.out_result, 32'd2);
    drive(AluSrl, 1'b1, 32'h8000_0000, 32'd36, 32'd0);
    tick();
    chk("srl_result", bus.out_result, 32'h0800_0000);
    drive(AluAnd, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    tick();
    chk("and_result", bus.out_result, 32'h0000_F000);
    drive(AluOr, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    tick();
    chk("or_result", bus.out_result, 32'h0000_FFF0);
    drive(AluXor, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'd0);
    tick();
    chk("xor_result", bus.out_result, 32'h0000_0FF0);
    drive(AluAdd, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd2);
    tick();
    chk("add_wrap", bus.out_result, 32'd1);

    // Store: address = ra + offset, store data = rb, control passes through
    drive(AluAdd, 1'b0, 32'h100, 32'hABCD, 32'd8);
    bus.mem_write = 1'b1;
    bus.reg_write = 1'b0;
    bus.mode      = CacheUc;
    tick();
    chk("st_addr", bus.out_result, 32'h108);
    chk("st_data", bus.out_store_data, 32'hABCD);
    chk("st_mem_write", 32'(bus.out_mem_write), 32'd1);
    chk("st_reg_write", 32'(bus.out_reg_write), 32'd0);
    chk("st_mode", 32'(bus.out_mode), 32'(CacheUc));
    bus.mem_write = 1'b0;
    bus.mode      = CacheWb;
    bus.in_valid  = 1'b0;
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // MUL 3 * 4: four busy cycles, result visible five cycles after accept
    drive(AluMul, 1'b1, 32'd3, 32'd4, 32'd0);
    bus.reg_write = 1'b1;
    bus.reg_dest  = 5'd9;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mul_busy_out_valid", 32'(bus.out_valid), 32'd0);
      tick();
    end
    chk("mul_valid", 32'(bus.out_valid), 32'd1);
    chk("mul_result", bus.out_result, 32'd12);
    chk("mul_reg_dest", 32'(bus.out_reg_dest), 32'd9);
    chk("mul_after_in_ready", 32'(bus.in_ready), 32'd1);

    // Backpressure: hold MUL result for three cycles, then accept ADD 10 + 20
    bus.out_ready = 1'b0;
    drive(AluAdd, 1'b0, 32'd10, 32'd0, 32'd20);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_result", bus.out_result, 32'd12);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_next_result", bus.out_result, 32'd30);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", 32'(bus.out_valid), 32'd0);

    // Flush while MUL counter is 2: nothing ever emitted, concurrent input dropped
    drive(AluMul, 1'b1, 32'd5, 32'd6, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    flush = 1'b1;
    drive(AluAdd, 1'b0, 32'd1, 32'd0, 32'd1);
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flush_no_result", 32'(bus.out_valid), 32'd0);
    end

    // Flush clears a held output
    bus.out_ready = 1'b0;
    drive(AluAdd, 1'b0, 32'd2, 32'd0, 32'd2);
    tick();
    bus.in_valid = 1'b0;
    chk("pre_flush_valid", 32'(bus.out_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_cleared", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

`ifdef CPU_EXEC_FORWARD_EN
    // Forwarding on ra, then forwarding suppressed for register 0
    drive(AluAdd, 1'b0, 32'd50, 32'd0, 32'd1);
    bus.ra_id      = 5'd3;
    bus.fwd_valid  = 1'b1;
    bus.fwd_reg_id = 5'd3;
    bus.fwd_data   = 32'd100;
    tick();
    chk("fwd_hit", bus.out_result, 32'd101);
    bus.ra_id      = 5'd0;
    bus.fwd_reg_id = 5'd0;
    tick();
    chk("fwd_zero", bus.out_result, 32'd51);
    bus.in_valid  = 1'b0;
    bus.fwd_valid = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
